// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs,
// datapath select codes, FSM states and the bundled control word.
package cu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_XCHG = 6'b000101;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [1:0] ULA1_PC = 2'b00, ULA1_A = 2'b01;
   localparam logic [1:0] ULA2_B = 2'b00, ULA2_FOUR = 2'b01, ULA2_SEXT = 2'b10, ULA2_SEXT_SH2 = 2'b11;
   localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_MDR = 2'b11;
   localparam logic [2:0] ADDR_PC = 3'b000, ADDR_ALUOUT = 3'b001, ADDR_EXC = 3'b010;
   localparam logic [1:0] WR_RT = 2'b00, WR_RD = 2'b01, WR_RA = 2'b10, WR_RS = 2'b11;
   localparam logic [2:0] WD_ALUOUT = 3'b000, WD_MDR = 3'b001, WD_HI = 3'b010, WD_LO = 3'b011,
                          WD_SHIFT = 3'b100, WD_SLT = 3'b101, WD_A = 3'b110, WD_B = 3'b111;
   localparam logic [2:0] ULA_PASS = 3'b000, ULA_ADD = 3'b001, ULA_SUB = 3'b010,
                          ULA_AND = 3'b011, ULA_CMP = 3'b111;
   localparam logic [2:0] SH_NOP = 3'b000, SH_LOAD = 3'b001, SH_SLL = 3'b010,
                          SH_SRL = 3'b011, SH_SRA = 3'b100;
   localparam logic [1:0] AMT_SHAMT = 2'b00, AMT_B = 2'b01;
   // Shifter source: 0 selects A, 1 selects B.
   localparam logic       SRC_A = 1'b0, SRC_B = 1'b1;
   localparam logic       HL_MULT = 1'b0, HL_DIV = 1'b1;

   typedef enum logic [5:0] {
      S_FETCH, S_FETCH2, S_DECODE,
      S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_SLT, S_WB_ALU, S_WB_SLT,
      S_SH_LD, S_SH_SLL, S_SH_SRL, S_SH_SRA, S_WB_SH,
      S_JR, S_MULT_INIT, S_MULT_WAIT, S_MULT_LOAD, S_DIV_INIT, S_DIV_WAIT, S_DIV_LOAD,
      S_MFHI, S_MFLO, S_XCH1, S_XCH2, S_ADDIU_EX, S_ADDIU_WB, S_BEQ, S_BNE,
      S_JUMP, S_JAL_WR, S_MEM_ADDR, S_LW_READ, S_LW_MDR, S_LW_WB, S_SW_WRITE,
      S_EXC1, S_EXC2, S_EXC3, S_EXC4
   } state_t;

   typedef struct packed {
      logic       mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src;
      logic [1:0] mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size;
      logic [2:0] mux_address, mux_register_wd, ula, shift;
      logic       address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load;
      logic       a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr;
      logic       pc_write, is_beq, is_bne, mult_init, div_init;
   } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Multicycle Moore controller: every datapath control is a registered function
// of the state entered on the same clock edge.
module control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       reset_in,
   input  logic [5:0] opcode,
   input  logic [15:0] immediate,
   input  logic       overflow,
   input  logic       zero_div,
   input  logic       div_zero,
   input  logic       mult_stop,
   input  logic       div_stop,
   output logic       mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src,
   output logic [1:0] mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size,
   output logic [2:0] mux_address, mux_register_wd, ula, shift,
   output logic       address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load,
   output logic       a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr,
   output logic       pc_write, is_beq, is_bne, mult_init, div_init
);

   state_t     state, next_state;
   ctrl_t      ctrl, next_ctrl;
   logic [5:0] funct;
   logic       unused_imm;

   assign funct      = immediate[5:0];
   assign unused_imm = ^immediate[15:6];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         state <= S_FETCH;
         ctrl  <= '0;
      end else begin
         state <= next_state;
         ctrl  <= next_ctrl;
      end
   end

   // NOTE: each combinational output gets a default before the case so that no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_FETCH2;
         S_FETCH2: next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD:  next_state = S_EX_ADD;
                     FN_SUB:  next_state = S_EX_SUB;
                     FN_AND:  next_state = S_EX_AND;
                     FN_SLT:  next_state = S_EX_SLT;
                     FN_SLL, FN_SRL, FN_SRA: next_state = S_SH_LD;
                     FN_JR:   next_state = S_JR;
                     FN_MULT: next_state = S_MULT_INIT;
                     FN_DIV:  next_state = S_DIV_INIT;
                     FN_MFHI: next_state = S_MFHI;
                     FN_MFLO: next_state = S_MFLO;
                     FN_XCHG: next_state = S_XCH1;
                     default: next_state = S_EXC1;
                  endcase
               end
               OP_ADDIU:     next_state = S_ADDIU_EX;
               OP_BEQ:       next_state = S_BEQ;
               OP_BNE:       next_state = S_BNE;
               OP_J:         next_state = S_JUMP;
               OP_JAL:       next_state = S_JAL_WR;
               OP_LW, OP_SW: next_state = S_MEM_ADDR;
               default:      next_state = S_EXC1;
            endcase
         end
         S_EX_ADD, S_EX_SUB: next_state = overflow ? S_EXC1 : S_WB_ALU;
         S_EX_AND:  next_state = S_WB_ALU;
         S_EX_SLT:  next_state = S_WB_SLT;
         S_SH_LD: begin
            case (funct)
               FN_SLL:  next_state = S_SH_SLL;
               FN_SRL:  next_state = S_SH_SRL;
               default: next_state = S_SH_SRA;
            endcase
         end
         S_SH_SLL, S_SH_SRL, S_SH_SRA: next_state = S_WB_SH;
         S_MULT_INIT: next_state = S_MULT_WAIT;
         S_MULT_WAIT: next_state = mult_stop ? S_MULT_LOAD : S_MULT_WAIT;
         S_DIV_INIT:  next_state = S_DIV_WAIT;
         // A divide-by-zero report wins over a simultaneous done.
         S_DIV_WAIT:  next_state = (zero_div || div_zero) ? S_EXC1 :
                                   (div_stop ? S_DIV_LOAD : S_DIV_WAIT);
         S_XCH1:      next_state = S_XCH2;
         S_ADDIU_EX:  next_state = S_ADDIU_WB;
         S_JAL_WR:    next_state = S_JUMP;
         S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
         S_LW_READ:   next_state = S_LW_MDR;
         S_LW_MDR:    next_state = S_LW_WB;
         S_EXC1:      next_state = S_EXC2;
         S_EXC2:      next_state = S_EXC3;
         S_EXC3:      next_state = S_EXC4;
         default:     next_state = S_FETCH;
      endcase
   end

   // Control word for the state being entered, so it is registered alongside it.
   always_comb begin
      next_ctrl = '0;
      case (next_state)
         S_FETCH2: begin
            next_ctrl.ir_load  = 1'b1;  next_ctrl.ula = ULA_ADD;
            next_ctrl.mux_ula1 = ULA1_PC; next_ctrl.mux_ula2 = ULA2_FOUR;
            next_ctrl.pc_write = 1'b1;  next_ctrl.mux_pc = PC_ALU;
         end
         S_DECODE: begin
            next_ctrl.a_load = 1'b1; next_ctrl.b_load = 1'b1; next_ctrl.ula = ULA_ADD;
            next_ctrl.mux_ula1 = ULA1_PC; next_ctrl.mux_ula2 = ULA2_SEXT_SH2;
            next_ctrl.ula_out_load = 1'b1;
         end
         S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_SLT: begin
            next_ctrl.mux_ula1 = ULA1_A; next_ctrl.mux_ula2 = ULA2_B; next_ctrl.ula_out_load = 1'b1;
            next_ctrl.ula = (next_state == S_EX_ADD) ? ULA_ADD :
                            (next_state == S_EX_SUB) ? ULA_SUB :
                            (next_state == S_EX_AND) ? ULA_AND : ULA_CMP;
         end
         S_WB_ALU: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RD; next_ctrl.mux_register_wd = WD_ALUOUT; end
         S_WB_SLT: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RD; next_ctrl.mux_register_wd = WD_SLT; end
         S_SH_LD: begin
            next_ctrl.shift = SH_LOAD; next_ctrl.mux_shift_src = SRC_B; next_ctrl.mux_shift_amt = AMT_SHAMT;
         end
         S_SH_SLL: next_ctrl.shift = SH_SLL;
         S_SH_SRL: next_ctrl.shift = SH_SRL;
         S_SH_SRA: next_ctrl.shift = SH_SRA;
         S_WB_SH:  begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RD; next_ctrl.mux_register_wd = WD_SHIFT; end
         S_JR: begin
            next_ctrl.ula = ULA_PASS; next_ctrl.mux_ula1 = ULA1_A;
            next_ctrl.pc_write = 1'b1; next_ctrl.mux_pc = PC_ALU;
         end
         S_MULT_INIT: next_ctrl.mult_init = 1'b1;
         S_MULT_LOAD: begin
            next_ctrl.high_load = 1'b1; next_ctrl.low_load = 1'b1;
            next_ctrl.mux_high = HL_MULT; next_ctrl.mux_low = HL_MULT;
         end
         S_DIV_INIT: next_ctrl.div_init = 1'b1;
         S_DIV_LOAD: begin
            next_ctrl.high_load = 1'b1; next_ctrl.low_load = 1'b1;
            next_ctrl.mux_high = HL_DIV; next_ctrl.mux_low = HL_DIV;
         end
         S_MFHI: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RD; next_ctrl.mux_register_wd = WD_HI; end
         S_MFLO: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RD; next_ctrl.mux_register_wd = WD_LO; end
         S_XCH1: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RT; next_ctrl.mux_register_wd = WD_A; end
         S_XCH2: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RS; next_ctrl.mux_register_wd = WD_B; end
         S_ADDIU_EX, S_MEM_ADDR: begin
            next_ctrl.mux_ula1 = ULA1_A; next_ctrl.mux_ula2 = ULA2_SEXT;
            next_ctrl.ula = ULA_ADD; next_ctrl.ula_out_load = 1'b1;
         end
         S_ADDIU_WB: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RT; next_ctrl.mux_register_wd = WD_ALUOUT; end
         S_BEQ, S_BNE: begin
            next_ctrl.ula = ULA_SUB; next_ctrl.mux_ula1 = ULA1_A; next_ctrl.mux_ula2 = ULA2_B;
            next_ctrl.mux_pc = PC_ALUOUT;
            next_ctrl.is_beq = (next_state == S_BEQ); next_ctrl.is_bne = (next_state == S_BNE);
         end
         S_JUMP:   begin next_ctrl.pc_write = 1'b1; next_ctrl.mux_pc = PC_JUMP; end
         S_JAL_WR: begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RA; next_ctrl.mux_register_wd = WD_ALUOUT; end
         S_LW_READ: next_ctrl.mux_address = ADDR_ALUOUT;
         S_LW_MDR:  next_ctrl.mdr_load = 1'b1;
         S_LW_WB:   begin next_ctrl.reg_wr = 1'b1; next_ctrl.mux_register_wr = WR_RT; next_ctrl.mux_register_wd = WD_MDR; end
         S_SW_WRITE: begin next_ctrl.mux_address = ADDR_ALUOUT; next_ctrl.memory_wr = 1'b1; end
         S_EXC1: begin
            next_ctrl.ula = ULA_SUB; next_ctrl.mux_ula1 = ULA1_PC; next_ctrl.mux_ula2 = ULA2_FOUR;
            next_ctrl.epc_load = 1'b1;
         end
         S_EXC2: next_ctrl.mux_address = ADDR_EXC;
         S_EXC3: next_ctrl.mdr_load = 1'b1;
         S_EXC4: begin next_ctrl.pc_write = 1'b1; next_ctrl.mux_pc = PC_MDR; end
         default: next_ctrl = '0;
      endcase
   end

   assign {mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src,
           mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size,
           mux_address, mux_register_wd, ula, shift,
           address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load,
           a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr,
           pc_write, is_beq, is_bne, mult_init, div_init} = ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction micro-step model queues the
// expected control word for every cycle; a monitor compares on the falling edge.
module tb_control_unit;

   typedef struct packed {
      logic       mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src;
      logic [1:0] mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size;
      logic [2:0] mux_address, mux_register_wd, ula, shift;
      logic       address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load;
      logic       a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr;
      logic       pc_write, is_beq, is_bne, mult_init, div_init;
   } ctl_t;

   typedef struct {
      ctl_t  exp;
      logic  ms;
      logic  ds;
      string name;
   } step_t;

   logic        clk = 1'b0;
   logic        reset_in, overflow, zero_div, div_zero, mult_stop, div_stop;
   logic [5:0]  opcode;
   logic [15:0] immediate;
   logic        mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src;
   logic [1:0]  mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size;
   logic [2:0]  mux_address, mux_register_wd, ula, shift;
   logic        address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load;
   logic        a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr;
   logic        pc_write, is_beq, is_bne, mult_init, div_init;
   ctl_t        act;

   control_unit dut (
      .clk(clk), .reset_in(reset_in), .opcode(opcode), .immediate(immediate),
      .overflow(overflow), .zero_div(zero_div), .div_zero(div_zero),
      .mult_stop(mult_stop), .div_stop(div_stop),
      .mux_memory_wd(mux_memory_wd), .mux_high(mux_high), .mux_low(mux_low),
      .mux_extend(mux_extend), .mux_b(mux_b), .mux_shift_src(mux_shift_src),
      .mux_shift_amt(mux_shift_amt), .mux_a(mux_a), .mux_ula1(mux_ula1), .mux_ula2(mux_ula2),
      .mux_pc(mux_pc), .mux_register_wr(mux_register_wr), .load_size(load_size),
      .mux_address(mux_address), .mux_register_wd(mux_register_wd), .ula(ula), .shift(shift),
      .address_rg_load(address_rg_load), .epc_load(epc_load), .mdr_load(mdr_load),
      .ir_load(ir_load), .high_load(high_load), .low_load(low_load), .a_load(a_load),
      .b_load(b_load), .ula_out_load(ula_out_load), .store_size(store_size),
      .memory_wr(memory_wr), .reg_wr(reg_wr), .pc_write(pc_write), .is_beq(is_beq),
      .is_bne(is_bne), .mult_init(mult_init), .div_init(div_init)
   );

   assign act = {mux_memory_wd, mux_high, mux_low, mux_extend, mux_b, mux_shift_src,
                 mux_shift_amt, mux_a, mux_ula1, mux_ula2, mux_pc, mux_register_wr, load_size,
                 mux_address, mux_register_wd, ula, shift,
                 address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load,
                 a_load, b_load, ula_out_load, store_size, memory_wr, reg_wr,
                 pc_write, is_beq, is_bne, mult_init, div_init};

   always #5 clk = ~clk;

   step_t       plan[$];
   ctl_t        exp_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad = 0;
   logic [5:0]  cur_op;
   logic [15:0] cur_imm;
   logic        cur_ovf, cur_zd, cur_dz;
   ctl_t        mon_exp;
   string       mon_name;

   // Monitor: one queued expectation per cycle, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         total++;
         if (act !== mon_exp) begin
            bad++;
            $display("FAIL %s op=%b fn=%b: got %h expected %h", mon_name, cur_op, cur_imm[5:0], act, mon_exp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input string name, input ctl_t e);
      step_t s;
      s.exp = e; s.ms = 1'b0; s.ds = 1'b0; s.name = name;
      plan.push_back(s);
   endtask

   task automatic add_wait(input string name, input logic ms, input logic ds);
      step_t s;
      s.exp = '0; s.ms = ms; s.ds = ds; s.name = name;
      plan.push_back(s);
   endtask

   task automatic add_exc();
      ctl_t e;
      e = '0; e.ula = 3'b010; e.mux_ula2 = 2'b01; e.epc_load = 1'b1; add("exc1_epc", e);
      e = '0; e.mux_address = 3'b010;                                add("exc2_vec", e);
      e = '0; e.mdr_load = 1'b1;                                     add("exc3_mdr", e);
      e = '0; e.pc_write = 1'b1; e.mux_pc = 2'b11;                   add("exc4_pc", e);
   endtask

   task automatic add_wb(input string name, input logic [1:0] wr, input logic [2:0] wd);
      ctl_t e;
      e = '0; e.reg_wr = 1'b1; e.mux_register_wr = wr; e.mux_register_wd = wd;
      add(name, e);
   endtask

   // Reference model: the cycle-by-cycle micro-steps each instruction must produce.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                        input logic dz, input int nwait);
      ctl_t e;
      plan.delete();
      e = '0; add("fetch", e);
      e = '0; e.ir_load = 1'b1; e.ula = 3'b001; e.mux_ula2 = 2'b01; e.pc_write = 1'b1; add("fetch2", e);
      e = '0; e.a_load = 1'b1; e.b_load = 1'b1; e.ula = 3'b001; e.mux_ula2 = 2'b11;
      e.ula_out_load = 1'b1; add("decode", e);
      if (op == 6'b000000) begin
         case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b101010: begin
               e = '0; e.mux_ula1 = 2'b01; e.ula_out_load = 1'b1;
               e.ula = (fn == 6'b100000) ? 3'b001 : (fn == 6'b100010) ? 3'b010 :
                       (fn == 6'b100100) ? 3'b011 : 3'b111;
               add("r_exec", e);
               if (ovf && (fn == 6'b100000 || fn == 6'b100010)) add_exc();
               else add_wb("r_wb", 2'b01, (fn == 6'b101010) ? 3'b101 : 3'b000);
            end
            6'b000000, 6'b000010, 6'b000011: begin
               e = '0; e.shift = 3'b001; e.mux_shift_src = 1'b1; add("sh_load", e);
               e = '0; e.shift = (fn == 6'b000000) ? 3'b010 : (fn == 6'b000010) ? 3'b011 : 3'b100;
               add("sh_op", e);
               add_wb("sh_wb", 2'b01, 3'b100);
            end
            6'b001000: begin
               e = '0; e.mux_ula1 = 2'b01; e.pc_write = 1'b1; add("jr", e);
            end
            6'b011000: begin
               e = '0; e.mult_init = 1'b1; add("mult_init", e);
               for (int i = 1; i <= nwait; i++) add_wait("mult_wait", i == nwait, 1'b0);
               e = '0; e.high_load = 1'b1; e.low_load = 1'b1; add("mult_hilo", e);
            end
            6'b011010: begin
               e = '0; e.div_init = 1'b1; add("div_init", e);
               if (dz) begin
                  add_wait("div_wait_zero", 1'b0, 1'b0);
                  add_exc();
               end else begin
                  for (int i = 1; i <= nwait; i++) add_wait("div_wait", 1'b0, i == nwait);
                  e = '0; e.high_load = 1'b1; e.low_load = 1'b1; e.mux_high = 1'b1; e.mux_low = 1'b1;
                  add("div_hilo", e);
               end
            end
            6'b010000: add_wb("mfhi", 2'b01, 3'b010);
            6'b010010: add_wb("mflo", 2'b01, 3'b011);
            6'b000101: begin
               add_wb("xchg_rt", 2'b00, 3'b110);
               add_wb("xchg_rs", 2'b11, 3'b111);
            end
            default: add_exc();
         endcase
      end else begin
         case (op)
            6'b001001, 6'b100011, 6'b101011: begin
               e = '0; e.mux_ula1 = 2'b01; e.mux_ula2 = 2'b10; e.ula = 3'b001; e.ula_out_load = 1'b1;
               add((op == 6'b001001) ? "addiu_exec" : "mem_addr", e);
               if (op == 6'b001001) add_wb("addiu_wb", 2'b00, 3'b000);
               else if (op == 6'b100011) begin
                  e = '0; e.mux_address = 3'b001; add("lw_read", e);
                  e = '0; e.mdr_load = 1'b1;      add("lw_mdr", e);
                  add_wb("lw_wb", 2'b00, 3'b001);
               end else begin
                  e = '0; e.mux_address = 3'b001; e.memory_wr = 1'b1; add("sw_write", e);
               end
            end
            6'b000100, 6'b000101: begin
               e = '0; e.ula = 3'b010; e.mux_ula1 = 2'b01; e.mux_pc = 2'b01;
               e.is_beq = (op == 6'b000100); e.is_bne = (op == 6'b000101);
               add("branch", e);
            end
            6'b000010, 6'b000011: begin
               if (op == 6'b000011) add_wb("jal_link", 2'b10, 3'b000);
               e = '0; e.pc_write = 1'b1; e.mux_pc = 2'b10; add("jump", e);
            end
            default: add_exc();
         endcase
      end
   endtask

   // Drives each planned cycle; a reset pulse may replace the rest of the plan.
   task automatic run(input logic [5:0] op, input logic [15:0] imm, input logic ovf,
                      input logic dz, input int nwait, input int reset_at);
      logic pick;
      pick = 1'($urandom);
      cur_op = op; cur_imm = imm; cur_ovf = ovf;
      cur_zd = dz & pick; cur_dz = dz & ~pick;
      build(op, imm[5:0], ovf, dz, nwait);
      foreach (plan[k]) begin
         @(posedge clk); #1;
         reset_in  = (k == reset_at);
         opcode    = cur_op;  immediate = cur_imm;
         overflow  = cur_ovf; zero_div  = cur_zd; div_zero = cur_dz;
         mult_stop = plan[k].ms; div_stop = plan[k].ds;
         exp_q.push_back(plan[k].exp);
         name_q.push_back((k == reset_at) ? {plan[k].name, "_rst"} : plan[k].name);
         if (k == reset_at) break;
      end
   endtask

   function automatic logic [5:0] rand_bad_op();
      logic [5:0] v;
      do v = 6'($urandom);
      while (v inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                       6'b001001, 6'b100011, 6'b101011});
      return v;
   endfunction

   function automatic logic [5:0] rand_bad_fn();
      logic [5:0] v;
      do v = 6'($urandom);
      while (v inside {6'b000000, 6'b000010, 6'b000011, 6'b000101, 6'b001000, 6'b010000,
                       6'b010010, 6'b011000, 6'b011010, 6'b100000, 6'b100010, 6'b100100, 6'b101010});
      return v;
   endfunction

   logic [5:0] r_ops [8]  = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                              6'b001001, 6'b100011, 6'b101011};
   logic [5:0] r_fns [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b000101, 6'b001000, 6'b010000,
                              6'b010010, 6'b011000, 6'b011010, 6'b100000, 6'b100010, 6'b100100, 6'b101010};

   initial begin
      logic [5:0] op, fn;
      int         rst_at;
      reset_in = 1'b1; overflow = 1'b0; zero_div = 1'b0; div_zero = 1'b0;
      mult_stop = 1'b0; div_stop = 1'b0; opcode = '0; immediate = '0;
      cur_op = '0; cur_imm = '0; cur_ovf = 1'b0; cur_zd = 1'b0; cur_dz = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back('0); name_q.push_back("reset_hold");

      run(6'b001001, 16'h1234, 1'b1, 1'b0, 1, -1);              // addiu ignores overflow
      run(6'b000000, 16'h0824, 1'b0, 1'b0, 1, -1);              // and
      run(6'b000000, 16'h001a, 1'b0, 1'b0, 5, -1);              // div, done after 5 waits
      run(6'b000000, 16'h001a, 1'b0, 1'b1, 5, -1);              // div by zero
      run(6'b000000, {5'd0, 5'd1, 6'b000011}, 1'b0, 1'b0, 1, -1); // sra shamt 1
      run(6'b000000, 16'h0020, 1'b1, 1'b0, 1, -1);              // add overflow trap
      run(6'b000000, 16'h0018, 1'b0, 1'b0, 4, 5);               // reset inside mult wait
      run(6'b111111, 16'h0000, 1'b0, 1'b0, 1, -1);              // unknown opcode
      run(6'b000000, 16'h003f, 1'b0, 1'b0, 1, -1);              // unknown funct

      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 9))
            0:       begin op = rand_bad_op(); fn = 6'($urandom); end
            1:       begin op = 6'b000000; fn = rand_bad_fn(); end
            2, 3, 4: begin op = 6'b000000; fn = r_fns[$urandom_range(0, 12)]; end
            default: begin op = r_ops[$urandom_range(0, 7)]; fn = 6'($urandom); end
         endcase
         rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
         run(op, {10'($urandom), fn}, 1'($urandom), ($urandom_range(0, 2) == 0),
             $urandom_range(1, 6), rst_at);
      end

      for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
